// File: rtl/pwm_sample_player.sv
// rtl/pwm_sample_player.sv - sample FIFO feeding a one-sample-per-period PWM DAC driver
module pwm_sample_player #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PRESCALE   = 1,
    parameter int REPEAT     = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [WIDTH-1:0]              sample_in,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    output logic                          pwm_out,
    output logic                          period_start,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          playing
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = $clog2(PRESCALE + 1);
    localparam int RW = $clog2(REPEAT + 1);

    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [RW-1:0]    REP_LAST = RW'(REPEAT - 1);
    localparam logic [LW-1:0]    LVL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [WIDTH-1:0] r_duty;
    logic [WIDTH-1:0] r_cnt;
    logic [PW-1:0]    r_pre;
    logic [RW-1:0]    r_rep;
    logic             r_pwm;
    logic             r_period_start;
    logic             r_underrun;

    logic w_active;
    logic w_tick;
    logic w_period_end;
    logic w_push;
    logic w_has_data;
    logic w_pop;
    logic w_start;
    logic w_underrun;
    logic w_rep_inc;
    logic w_rep_clr;

    assign w_active     = (r_state != S_IDLE);
    assign w_tick       = w_active && (r_pre == PRE_LAST);
    assign w_period_end = w_tick && (r_cnt == CNT_MAX);
    assign w_has_data   = (r_level != '0);
    assign sample_ready = (r_level != LVL_FULL);
    assign w_push       = sample_valid && sample_ready;

    assign fifo_level   = r_level;
    assign playing      = w_active;
    assign pwm_out      = r_pwm;
    assign period_start = r_period_start;
    assign underrun     = r_underrun;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: start on data, stop only at a period boundary
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (en && w_has_data) begin
                    w_state_nxt = S_PLAY;
                end
            end
            S_PLAY: begin
                if (w_period_end) begin
                    if ((r_rep >= REP_LAST) && !en) begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (!en) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_period_end) begin
                    w_state_nxt = S_IDLE;
                end else if (en) begin
                    w_state_nxt = S_PLAY;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Control outputs: pop/replay/underrun decisions made at period boundaries
    always_comb begin
        w_pop      = 1'b0;
        w_start    = 1'b0;
        w_underrun = 1'b0;
        w_rep_inc  = 1'b0;
        w_rep_clr  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en && w_has_data) begin
                    w_pop     = 1'b1;
                    w_start   = 1'b1;
                    w_rep_clr = 1'b1;
                end
            end
            S_PLAY: begin
                if (w_period_end) begin
                    if (r_rep < REP_LAST) begin
                        w_rep_inc = 1'b1;
                        w_start   = 1'b1;
                    end else if (en) begin
                        w_start   = 1'b1;
                        w_rep_clr = 1'b1;
                        if (w_has_data) begin
                            w_pop = 1'b1;
                        end else begin
                            w_underrun = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // Sample storage; contents need no reset since the pointers are flushed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= sample_in;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Duty register loads the FIFO head on each pop; otherwise held (replay/underrun)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty <= '0;
        end else if (w_pop) begin
            r_duty <= r_mem[r_rd_ptr];
        end
    end

    // Prescaler and period counter; both parked at zero while idle
    always_ff @(posedge clk) begin
        if (rst || !w_active) begin
            r_pre <= '0;
            r_cnt <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
            r_cnt <= r_cnt + WIDTH'(1);
        end else begin
            r_pre <= r_pre + PW'(1);
        end
    end

    // Repeat counter: periods already played with the current duty
    always_ff @(posedge clk) begin
        if (rst || w_rep_clr) begin
            r_rep <= '0;
        end else if (w_rep_inc) begin
            r_rep <= r_rep + RW'(1);
        end
    end

    // Registered PWM comparator and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm          <= 1'b0;
            r_period_start <= 1'b0;
            r_underrun     <= 1'b0;
        end else begin
            r_pwm          <= w_active && (r_cnt < r_duty);
            r_period_start <= w_start;
            r_underrun     <= w_underrun;
        end
    end

endmodule

// File: tb/tb_pwm_sample_player.sv
// tb/tb_pwm_sample_player.sv - scoreboard bench for pwm_sample_player
module tb_pwm_sample_player;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] en_i   = '0;
    logic [1:0] vld_i  = '0;
    logic [7:0] din0   = '0;
    logic [7:0] din1   = '0;
    logic [1:0] rdy_o;
    logic [1:0] pwm_o;
    logic [1:0] ps_o;
    logic [1:0] ur_o;
    logic [1:0] play_o;
    logic [2:0] lvl0;
    logic [2:0] lvl1;

    int n_checks = 0;
    int n_errors = 0;

    int exp_q0[$];
    int exp_q1[$];

    int hc[2];
    int ln[2];
    int exph[2];
    bit inp[2];

    always #5 clk = ~clk;

    pwm_sample_player #(.WIDTH(8), .FIFO_DEPTH(4), .PRESCALE(1), .REPEAT(1)) u_dut0 (
        .clk(clk), .rst(rst), .en(en_i[0]), .sample_in(din0), .sample_valid(vld_i[0]),
        .sample_ready(rdy_o[0]), .pwm_out(pwm_o[0]), .period_start(ps_o[0]),
        .underrun(ur_o[0]), .fifo_level(lvl0), .playing(play_o[0])
    );

    pwm_sample_player #(.WIDTH(8), .FIFO_DEPTH(4), .PRESCALE(3), .REPEAT(2)) u_dut1 (
        .clk(clk), .rst(rst), .en(en_i[1]), .sample_in(din1), .sample_valid(vld_i[1]),
        .sample_ready(rdy_o[1]), .pwm_out(pwm_o[1]), .period_start(ps_o[1]),
        .underrun(ur_o[1]), .fifo_level(lvl1), .playing(play_o[1])
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected period: duty played and whether it starts with an underrun
    task automatic sb_push(input int d, input int duty, input int ur);
        if (d == 0) exp_q0.push_back((ur << 8) | duty);
        else        exp_q1.push_back((ur << 8) | duty);
    endtask

    // Period monitor: pops one expectation per period_start, counts high clocks
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int per;
            int pre;
            int e;
            bit got_e;
            per = (d == 0) ? 256 : 768;
            pre = (d == 0) ? 1 : 3;
            if (rst) begin
                inp[d] = 1'b0;
            end else begin
                if (inp[d]) begin
                    hc[d] += int'(pwm_o[d]);
                    ln[d]++;
                    if (ln[d] == per) begin
                        check($sformatf("high_clks_dut%0d", d), hc[d], exph[d]);
                        inp[d] = 1'b0;
                    end
                end
                if (ps_o[d]) begin
                    if (inp[d]) check($sformatf("period_len_dut%0d", d), ln[d], per);
                    got_e = 1'b0;
                    e = 0;
                    if (d == 0 && exp_q0.size() > 0) begin e = exp_q0.pop_front(); got_e = 1'b1; end
                    if (d == 1 && exp_q1.size() > 0) begin e = exp_q1.pop_front(); got_e = 1'b1; end
                    check($sformatf("sb_has_entry_dut%0d", d), int'(got_e), 1);
                    exph[d] = (e & 255) * pre;
                    check($sformatf("underrun_flag_dut%0d", d), int'(ur_o[d]), (e >> 8) & 1);
                    inp[d] = 1'b1;
                    hc[d] = 0;
                    ln[d] = 0;
                end else if (ur_o[d]) begin
                    check($sformatf("underrun_without_start_dut%0d", d), int'(ur_o[d]), 0);
                end
            end
        end
    end

    task automatic push_one(input int d, input int val);
        int cyc = 0;
        while (!rdy_o[d] && cyc < 2000) begin @(negedge clk); cyc++; end
        check("push_ready_timeout", int'(rdy_o[d]), 1);
        vld_i[d] = 1'b1;
        if (d == 0) din0 = val[7:0]; else din1 = val[7:0];
        @(negedge clk);
        vld_i[d] = 1'b0;
    endtask

    task automatic wait_ps(input int d, input int n);
        int seen = 0;
        int cyc = 0;
        while (seen < n && cyc < n * 1000 + 100) begin
            @(negedge clk);
            cyc++;
            if (ps_o[d]) seen++;
        end
        if (seen < n) check("wait_period_start_timeout", seen, n);
    endtask

    task automatic wait_idle(input int d);
        int cyc = 0;
        while (play_o[d] && cyc < 1000) begin @(negedge clk); cyc++; end
        check("idle_playing", int'(play_o[d]), 0);
        check("idle_pwm_out", int'(pwm_o[d]), 0);
    endtask

    initial begin
        int vals[5];
        vals = '{10, 20, 30, 40, 50};

        repeat (3) @(negedge clk);
        check("rst_pwm_out", int'(pwm_o[0]), 0);
        check("rst_sample_ready", int'(rdy_o[0]), 1);
        check("rst_fifo_level", int'(lvl0), 0);
        check("rst_playing", int'(play_o[0]), 0);
        check("rst_period_start", int'(ps_o[0]), 0);
        check("rst_underrun", int'(ur_o[0]), 0);
        check("rst_playing_dut1", int'(play_o[1]), 0);
        rst = 1'b0;
        @(negedge clk);

        // Single sample 64: latency and duty
        en_i[0] = 1'b1;
        sb_push(0, 64, 0);
        push_one(0, 64);
        check("a_level_after_push", int'(lvl0), 1);
        check("a_no_start_yet", int'(ps_o[0]), 0);
        @(negedge clk);
        check("a_period_start", int'(ps_o[0]), 1);
        check("a_playing", int'(play_o[0]), 1);
        check("a_pwm_first_clk", int'(pwm_o[0]), 0);
        @(negedge clk);
        check("a_pwm_second_clk", int'(pwm_o[0]), 1);
        check("a_start_pulse_width", int'(ps_o[0]), 0);
        repeat (100) @(negedge clk);
        en_i[0] = 1'b0;
        wait_idle(0);

        // Fill FIFO while disabled, then backpressure release
        for (int i = 0; i < 5; i++) sb_push(0, vals[i], 0);
        vld_i[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin din0 = vals[i][7:0]; @(negedge clk); end
        din0 = vals[4][7:0];
        check("b_ready_full", int'(rdy_o[0]), 0);
        check("b_level_full", int'(lvl0), 4);
        @(negedge clk);
        check("b_level_held", int'(lvl0), 4);
        en_i[0] = 1'b1;
        @(negedge clk);
        check("b_start_on_enable", int'(ps_o[0]), 1);
        check("b_ready_after_pop", int'(rdy_o[0]), 1);
        check("b_level_after_pop", int'(lvl0), 3);
        @(negedge clk);
        vld_i[0] = 1'b0;
        check("b_level_after_5th", int'(lvl0), 4);
        wait_ps(0, 4);
        repeat (50) @(negedge clk);
        en_i[0] = 1'b0;
        wait_idle(0);

        // Underrun: one sample then nothing, duty held
        en_i[0] = 1'b1;
        sb_push(0, 128, 0);
        sb_push(0, 128, 1);
        sb_push(0, 128, 1);
        push_one(0, 128);
        wait_ps(0, 3);
        repeat (50) @(negedge clk);
        en_i[0] = 1'b0;
        wait_idle(0);

        // Duty extremes 0 and 255
        sb_push(0, 0, 0);
        sb_push(0, 255, 0);
        push_one(0, 0);
        push_one(0, 255);
        check("d_level_two", int'(lvl0), 2);
        en_i[0] = 1'b1;
        wait_ps(0, 2);
        repeat (50) @(negedge clk);
        en_i[0] = 1'b0;
        wait_idle(0);

        // Prescale 3, repeat 2
        sb_push(1, 10, 0);
        sb_push(1, 10, 0);
        sb_push(1, 20, 0);
        push_one(1, 10);
        push_one(1, 20);
        en_i[1] = 1'b1;
        @(negedge clk);
        check("e_start", int'(ps_o[1]), 1);
        check("e_level_after_pop", int'(lvl1), 1);
        wait_ps(1, 1);
        check("e_level_after_repeat", int'(lvl1), 1);
        wait_ps(1, 1);
        check("e_level_after_second_pop", int'(lvl1), 0);
        repeat (50) @(negedge clk);
        en_i[1] = 1'b0;
        @(negedge clk);
        check("e_drain_still_playing", int'(play_o[1]), 1);
        wait_idle(1);

        // Reset during play
        en_i[0] = 1'b1;
        sb_push(0, 200, 0);
        push_one(0, 200);
        wait_ps(0, 1);
        repeat (20) @(negedge clk);
        check("r_pwm_before_reset", int'(pwm_o[0]), 1);
        rst = 1'b1;
        en_i[0] = 1'b0;
        @(negedge clk);
        check("r_pwm_after_reset", int'(pwm_o[0]), 0);
        check("r_playing_after_reset", int'(play_o[0]), 0);
        check("r_level_after_reset", int'(lvl0), 0);
        check("r_ready_after_reset", int'(rdy_o[0]), 1);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        check("sb_left_dut0", exp_q0.size(), 0);
        check("sb_left_dut1", exp_q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
